// File: rtl/xmr_pipe_pkg.sv
// Shared encodings for the XMR drive pipeline: command codes, FSM states and
// a small command-decoding helper.
package xmr_pipe_pkg;

    localparam int MAX_STAGES = 8;

    typedef enum logic [1:0] {
        CMD_RELEASE = 2'b00,
        CMD_FORCE   = 2'b01,
        CMD_PULSE   = 2'b10,
        CMD_RSVD    = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DOWN = 2'b01,
        UP   = 2'b10
    } state_e;

    // True for the commands that engage the override at the leaf.
    function automatic logic sets_force(input cmd_e cmd);
        return (cmd == CMD_FORCE) || (cmd == CMD_PULSE);
    endfunction

endpackage

// File: rtl/xmr_drive_pipe_stage.sv
// One register slice of the XMR pipeline. Valid is reset; the payload has no
// reset and only loads when valid is high.
module xmr_pipe_stage #(
    parameter int PW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid,
    input  logic [PW-1:0] data,
    output logic          valid_q,
    output logic [PW-1:0] data_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid;
        end
    end

    always_ff @(posedge clk) begin
        if (valid) begin
            data_q <= data;
        end
    end

endmodule

// File: rtl/xmr_drive_pipe.sv
// Carries a force/release command down STAGES slices to a leaf override mux and
// returns a completion through an equal-depth upward pipeline.
module xmr_drive_pipe
    import xmr_pipe_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2,
    parameter int LEN_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_cmd,
    input  logic [WIDTH-1:0] req_data,
    input  logic [LEN_W-1:0] req_len,
    output logic             rsp_valid,
    output logic             rsp_err,
    input  logic [WIDTH-1:0] leaf_local,
    output logic [WIDTH-1:0] leaf_out,
    output logic             leaf_forced
);

    typedef struct packed {
        cmd_e             cmd;
        logic [WIDTH-1:0] data;
        logic [LEN_W-1:0] len;
    } down_pay_t;

    localparam int PAY_W = $bits(down_pay_t);

    if (STAGES < 0 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("xmr_drive_pipe: STAGES must be within 0..8");
    end

    // A zero length still yields a one-cycle pulse.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction

    state_e state_q;
    logic   ready_q;
    logic   accept;

    assign accept    = req_valid & ready_q;
    assign req_ready = ready_q;

    // Downward path: index 0 is the accepted command, index STAGES reaches the leaf.
    logic      dn_vld_p [STAGES+1];
    down_pay_t dn_pay_p [STAGES+1];

    assign dn_vld_p[0] = accept;
    assign dn_pay_p[0] = '{cmd: cmd_e'(req_cmd), data: req_data, len: req_len};

    for (genvar i = 0; i < STAGES; i++) begin : g_dn
        xmr_pipe_stage #(.PW(PAY_W)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid   (dn_vld_p[i]),
            .data    (dn_pay_p[i]),
            .valid_q (dn_vld_p[i+1]),
            .data_q  (dn_pay_p[i+1])
        );
    end

    logic      dn_vld;
    down_pay_t dn_pay;

    assign dn_vld = dn_vld_p[STAGES];
    assign dn_pay = dn_pay_p[STAGES];

    logic             forced_q;
    logic             pulse_q;
    logic [WIDTH-1:0] force_val_q;
    logic [LEN_W-1:0] cnt_q;
    logic             app_vld_p;
    logic             app_err_p;

    // Leaf apply stage: an arriving command always beats a pulse countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            forced_q    <= 1'b0;
            pulse_q     <= 1'b0;
            force_val_q <= '0;
            cnt_q       <= '0;
            app_vld_p   <= 1'b0;
            app_err_p   <= 1'b0;
        end else begin
            app_vld_p <= dn_vld;
            app_err_p <= dn_vld && (dn_pay.cmd == CMD_RSVD);
            if (dn_vld && dn_pay.cmd != CMD_RSVD) begin
                forced_q <= sets_force(dn_pay.cmd);
                pulse_q  <= (dn_pay.cmd == CMD_PULSE);
                cnt_q    <= (dn_pay.cmd == CMD_PULSE) ? clamp_len(dn_pay.len) : '0;
                if (sets_force(dn_pay.cmd)) begin
                    force_val_q <= dn_pay.data;
                end
            end else if (forced_q && pulse_q) begin
                if (cnt_q == LEN_W'(1)) begin
                    forced_q <= 1'b0;
                    pulse_q  <= 1'b0;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q - LEN_W'(1);
                end
            end
        end
    end

    assign leaf_forced = forced_q;
    assign leaf_out    = forced_q ? force_val_q : leaf_local;

    // Upward path: completion travels back carrying only the error flag.
    logic up_vld_p [STAGES+1];
    logic up_err_p [STAGES+1];

    assign up_vld_p[0] = app_vld_p;
    assign up_err_p[0] = app_err_p;

    for (genvar i = 0; i < STAGES; i++) begin : g_up
        xmr_pipe_stage #(.PW(1)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid   (up_vld_p[i]),
            .data    (up_err_p[i]),
            .valid_q (up_vld_p[i+1]),
            .data_q  (up_err_p[i+1])
        );
    end

    logic up_vld;
    logic up_err;
    logic rsp_valid_q;
    logic rsp_err_q;

    assign up_vld = up_vld_p[STAGES];
    assign up_err = up_err_p[STAGES];

    // Control FSM and response register; ready reopens with the response pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= up_vld;
            rsp_err_q   <= up_vld & up_err;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= DOWN;
                        ready_q <= 1'b0;
                    end
                end
                DOWN: begin
                    if (up_vld) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else if (app_vld_p) begin
                        state_q <= UP;
                    end
                end
                UP: begin
                    if (up_vld) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

endmodule
